// File: rtl/bus_reg_slave.sv
// rtl/bus_reg_slave.sv - register-bank bus slave with fixed-latency read responses
//
// Purpose: terminates the slave side of the communication bus. Writes land in
// one cycle; reads return a value snapshotted at acceptance after READ_LATENCY
// edges, held until the master handshakes with i_ready. The top address
// (NUM_REGS-1) is a read-only status word {drop_cnt, err_cnt}; writing it
// clears both counters.
//
// Ports:
//   i_clk        - clock, all state changes on the rising edge
//   i_reset      - synchronous active-high reset
//   i_addr       - request word address
//   i_write_data - write payload
//   i_write      - 1 = write, 0 = read (qualified by i_valid)
//   i_valid      - request present this cycle
//   i_ready      - master accepts the read response this cycle
//   o_read       - read response valid (registered)
//   o_read_data  - read response payload (registered)

module bus_reg_slave #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_REGS     = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_write,
  input  logic                  i_valid,
  input  logic                  i_ready,
  output logic                  o_read,
  output logic [DATA_WIDTH-1:0] o_read_data
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int IW = (NUM_REGS > 2) ? $clog2(NUM_REGS - 1) : 1;
  localparam int CW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

  // Address constants carry one extra bit so NUM_REGS == 2**ADDR_WIDTH still fits.
  localparam int unsigned          STAT_I      = NUM_REGS - 1;
  localparam logic [ADDR_WIDTH:0]  L_STAT      = STAT_I[ADDR_WIDTH:0];
  localparam int unsigned          WAIT_I      = (READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0;
  localparam logic [CW-1:0]        L_WAIT_INIT = WAIT_I[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_wait_cnt;
  logic [DATA_WIDTH-1:0] r_snap;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS-1];
  logic [HW-1:0]         r_drop_cnt;
  logic [HW-1:0]         r_err_cnt;

  logic [ADDR_WIDTH:0]   w_addr_ext;
  logic                  w_is_reg;
  logic                  w_is_stat;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_rd_val;

  assign w_addr_ext = {1'b0, i_addr};
  assign w_is_reg   = (w_addr_ext < L_STAT);
  assign w_is_stat  = (w_addr_ext == L_STAT);
  assign w_idx      = i_addr[IW-1:0];

  // Value a read accepted this cycle returns; counters are pre-edge values.
  always_comb begin
    w_rd_val = '0;
    if (w_is_reg)
      w_rd_val = r_regs[w_idx];
    else if (w_is_stat)
      w_rd_val = {r_drop_cnt, r_err_cnt};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_snap      <= '0;
      r_drop_cnt  <= '0;
      r_err_cnt   <= '0;
      o_read      <= 1'b0;
      o_read_data <= '0;
      for (int i = 0; i < NUM_REGS - 1; i++)
        r_regs[i] <= '0;
    end else begin
      // Any request outside IDLE is lost; the clear below only happens in IDLE.
      if (r_state != S_IDLE && i_valid && !(&r_drop_cnt))
        r_drop_cnt <= r_drop_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            if (i_write) begin
              if (w_is_reg) begin
                r_regs[w_idx] <= i_write_data;
              end else if (w_is_stat) begin
                r_drop_cnt <= '0;
                r_err_cnt  <= '0;
              end else if (!(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
              end
            end else begin
              r_snap <= w_rd_val;
              if (!w_is_reg && !w_is_stat && !(&r_err_cnt))
                r_err_cnt <= r_err_cnt + 1'b1;
              if (READ_LATENCY == 1) begin
                r_state     <= S_RESP;
                o_read      <= 1'b1;
                o_read_data <= w_rd_val;
              end else begin
                r_state    <= S_WAIT;
                r_wait_cnt <= L_WAIT_INIT;
              end
            end
          end
        end

        S_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state     <= S_RESP;
            o_read      <= 1'b1;
            o_read_data <= r_snap;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end

        S_RESP: begin
          // o_read_data is left alone so it keeps the last response value.
          if (i_ready) begin
            r_state <= S_IDLE;
            o_read  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          o_read  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_reg_slave.sv
// tb/tb_bus_reg_slave.sv - self-checking bench for bus_reg_slave

module tb_bus_reg_slave;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int NR = 16;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] write_data = '0;
  logic          write = 1'b0;
  logic          valid = 1'b0;
  logic          ready = 1'b0;
  logic          read;
  logic [DW-1:0] read_data;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q [$];

  bus_reg_slave #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_REGS    (NR),
    .READ_LATENCY(RL)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_addr      (addr),
    .i_write_data(write_data),
    .i_write     (write),
    .i_valid     (valid),
    .i_ready     (ready),
    .o_read      (read),
    .o_read_data (read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; write_data = d; write = 1'b1; valid = 1'b1;
    tick();
    valid = 1'b0; write = 1'b0;
  endtask

  // Issue a read, measure latency, hold ready low for 'hold' cycles, then handshake.
  task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
    int edges;
    logic [DW-1:0] want;
    logic [DW-1:0] held;
    exp_q.push_back(exp);
    addr = a; write = 1'b0; valid = 1'b1; ready = 1'b0;
    tick();
    valid = 1'b0;
    edges = 1;
    while (!read && edges < 16) begin
      tick();
      edges++;
    end
    check({tag, "_latency"}, edges, RL);
    want = exp_q.pop_front();
    check({tag, "_data"}, read_data, want);
    held = read_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_read"}, read, 1);
      check({tag, "_hold_data"}, read_data, held);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_hs_read_low"}, read, 0);
    check({tag, "_hs_data_kept"}, read_data, held);
  endtask

  initial begin
    logic [DW-1:0] want;

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    check("rst_read", read, 0);
    check("rst_data", read_data, 0);

    // Basic write then read
    do_write(16'd3, 32'hA5A5_0001);
    do_read("rd3", 16'd3, 32'hA5A5_0001, 0);

    // Stalled response
    do_write(16'd5, 32'h5555_0005);
    do_read("rd5_stall", 16'd5, 32'h5555_0005, 4);

    // Requests during WAIT/RESP are dropped
    do_write(16'd2, 32'h0000_2222);
    exp_q.push_back(32'h0000_2222);
    addr = 16'd2; write = 1'b0; valid = 1'b1;
    tick();
    addr = 16'd2; write = 1'b1; write_data = 32'h0000_1234; valid = 1'b1;
    tick();
    check("drop_read_up", read, 1);
    tick();
    want = exp_q.pop_front();
    check("drop_resp_data", read_data, want);
    ready = 1'b1;
    tick();
    ready = 1'b0; valid = 1'b0; write = 1'b0;
    check("drop_hs_low", read, 0);
    do_read("rd2_after_drop", 16'd2, 32'h0000_2222, 0);
    do_read("stat_drop3", 16'd15, 32'h0003_0000, 0);

    // Out-of-range accesses and status clear
    do_write(16'd15, 32'hDEAD_BEEF);
    do_write(16'h0100, 32'hFFFF_FFFF);
    do_read("rd_oor", 16'h0200, 32'h0000_0000, 0);
    do_read("rd0_untouched", 16'd0, 32'h0000_0000, 0);
    do_read("stat_err2", 16'd15, 32'h0000_0002, 0);
    do_write(16'd15, 32'h1234_5678);
    do_read("stat_cleared", 16'd15, 32'h0000_0000, 0);

    // Reset during WAIT
    do_write(16'd7, 32'h0000_0077);
    do_read("rd3_prefill", 16'd3, 32'hA5A5_0001, 0);
    addr = 16'd7; write = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_read", read, 0);
    check("midrst_data", read_data, 0);
    tick();
    tick();
    check("midrst_read_later", read, 0);
    do_read("post_rst_r3", 16'd3, 32'h0, 0);
    do_read("post_rst_r5", 16'd5, 32'h0, 0);
    do_read("post_rst_r7", 16'd7, 32'h0, 0);
    do_read("post_rst_stat", 16'd15, 32'h0, 0);

    // drop_cnt saturation
    do_write(16'd1, 32'h0000_0011);
    exp_q.push_back(32'h0000_0011);
    addr = 16'd1; write = 1'b0; valid = 1'b1;
    tick();
    addr = 16'd9;
    repeat (70000) tick();
    check("sat_read_up", read, 1);
    want = exp_q.pop_front();
    check("sat_resp_data", read_data, want);
    ready = 1'b1;
    tick();
    ready = 1'b0; valid = 1'b0;
    check("sat_hs_low", read, 0);
    do_read("stat_drop_sat", 16'd15, 32'hFFFF_0000, 0);

    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
